// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Drives a combinational gate through every input combination. After each
//   combination is applied it waits a programmable settle time, then samples
//   the gate output. The samples are assembled into a 2^NUM_IN-bit truth table.
//
//   Build option: define SWEEP_GRAY_EN to apply the combinations in reflected
//   Gray-code order, so only one input toggles per step. The table is indexed
//   by the binary value of dut_in in both modes.
//
// Parameters
//   NUM_IN  number of gate inputs (1..8)
//   SETTLE  cycles to wait after applying a combination before sampling (1..255)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        sweep request, sampled only when idle
//   dut_in       gate inputs; bit0 = in1
//   dut_out      gate output under characterisation
//   busy         sweep in progress
//   done         one-cycle pulse at sweep completion
//   table_out    captured table; bit k = gate output for input value k
//   table_valid  table_out holds a complete sweep
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | dut_in parked at 0, waiting for start
// SETTLE | current combination applied, counting settle cycles
// SAMPLE | capture dut_out into the table, then step or finish
// DONE   | done pulse, table_valid raised, return to IDLE

module truth_table_sweeper #(
    parameter int NUM_IN = 2,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [NUM_IN-1:0]      dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic [2**NUM_IN-1:0]   table_out,
    output logic                   table_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // idx carries one spare bit so the last-index compare can never wrap.
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [NUM_IN:0] IDX_LAST    = (NUM_IN + 1)'((2 ** NUM_IN) - 1);
    localparam logic [NUM_IN:0] IDX_ONE     = (NUM_IN + 1)'(1);

    state_t                state_q, state_d;
    logic [NUM_IN:0]       idx_q, idx_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [NUM_IN-1:0]     dut_in_d;
    logic                  busy_d;
    logic                  done_d;
    logic [2**NUM_IN-1:0]  table_d;
    logic                  valid_d;

    // Maps a sweep index to the combination applied to the gate.
    function automatic logic [NUM_IN-1:0] combo(input logic [NUM_IN:0] i);
`ifdef SWEEP_GRAY_EN
        combo = NUM_IN'(i ^ (i >> 1));
`else
        combo = NUM_IN'(i);
`endif
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dut_in_d = dut_in;
        busy_d   = busy;
        done_d   = 1'b0;
        table_d  = table_out;
        valid_d  = table_valid;

        case (state_q)
            ST_IDLE: begin
                busy_d   = 1'b0;
                dut_in_d = '0;
                if (start) begin
                    state_d = ST_SETTLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    table_d = '0;
                    valid_d = 1'b0;
                end
            end

            ST_SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                // dut_in already holds combo(idx), which is the binary table
                // position in either ordering.
                table_d[dut_in] = dut_out;
                if (idx_q == IDX_LAST) begin
                    state_d  = ST_DONE;
                    dut_in_d = '0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    valid_d  = 1'b1;
                end else begin
                    state_d  = ST_SETTLE;
                    idx_d    = idx_q + IDX_ONE;
                    dut_in_d = combo(idx_q + IDX_ONE);
                    cnt_d    = '0;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            dut_in      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            table_out   <= '0;
            table_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            dut_in      <= dut_in_d;
            busy        <= busy_d;
            done        <= done_d;
            table_out   <= table_d;
            table_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start [2];
    logic [1:0] dut_in0;
    logic [2:0] dut_in1;
    logic       dut_out0, dut_out1;
    logic       busy0, busy1, done0, done1, valid0, valid1;
    logic [3:0] tab0;
    logic [7:0] tab1;

    truth_table_sweeper #(.NUM_IN(2), .SETTLE(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .dut_in(dut_in0),
        .dut_out(dut_out0), .busy(busy0), .done(done0),
        .table_out(tab0), .table_valid(valid0));

    truth_table_sweeper #(.NUM_IN(3), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .dut_in(dut_in1),
        .dut_out(dut_out1), .busy(busy1), .done(done1),
        .table_out(tab1), .table_valid(valid1));

    logic [2:0] din_w  [2];
    logic [7:0] tab_w  [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic       valid_w[2];
    assign din_w[0]   = {1'b0, dut_in0};
    assign din_w[1]   = dut_in1;
    assign tab_w[0]   = {4'b0, tab0};
    assign tab_w[1]   = tab1;
    assign busy_w[0]  = busy0;
    assign busy_w[1]  = busy1;
    assign done_w[0]  = done0;
    assign done_w[1]  = done1;
    assign valid_w[0] = valid0;
    assign valid_w[1] = valid1;

    // gate functions: 0 = only {in2,in1}=10, 1 = 2-input XOR, 2 = AND3, 3 = OR3
    int   gsel  [2] = '{0, 2};
    logic nmask [2] = '{1'b0, 1'b0};
    bit   noise_en [2] = '{1'b0, 1'b0};

    function automatic logic gate(input int sel, input logic [2:0] x);
        case (sel)
            0:       gate = (x[1:0] == 2'b10);
            1:       gate = x[0] ^ x[1];
            2:       gate = &x;
            default: gate = |x;
        endcase
    endfunction

    // Outside the sample cycle the gate output is deliberately inverted.
    assign dut_out0 = gate(gsel[0], din_w[0]) ^ nmask[0];
    assign dut_out1 = gate(gsel[1], din_w[1]) ^ nmask[1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         nin [2] = '{2, 3};
    int         st  [2] = '{2, 1};
    bit         m_act [2], m_done [2], m_busy [2], m_valid [2];
    int         m_c   [2];
    logic [2:0] m_din [2];
    logic [7:0] m_tab [2];
    bit         chk_en = 1'b0;

    function automatic logic [2:0] ord(input int k);
        int v;
`ifdef SWEEP_GRAY_EN
        v = k ^ (k >> 1);
`else
        v = k;
`endif
        return v[2:0];
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_done[i] = 0; m_busy[i] = 0; m_valid[i] = 0;
            m_c[i] = 0; m_din[i] = '0; m_tab[i] = '0; start[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int  per;
                bit  samp;
                per  = st[i] + 1;
                chk("dut_in", i, 32'(din_w[i]), 32'(m_din[i]));
                chk("busy", i, 32'(busy_w[i]), 32'(m_busy[i]));
                chk("done", i, 32'(done_w[i]), 32'(m_done[i]));
                chk("table_out", i, 32'(tab_w[i]), 32'(m_tab[i]));
                chk("table_valid", i, 32'(valid_w[i]), 32'(m_valid[i]));
                samp = m_act[i] && (m_c[i] % per == st[i]);
                nmask[i] = noise_en[i] && !samp;
                if (rst) begin
                    m_act[i] = 0; m_done[i] = 0; m_busy[i] = 0; m_valid[i] = 0;
                    m_c[i] = 0; m_din[i] = '0; m_tab[i] = '0;
                end else if (m_act[i]) begin
                    if (samp) begin
                        m_tab[i][m_din[i]] = gate(gsel[i], m_din[i]);
                        if (m_c[i] / per == (1 << nin[i]) - 1) begin
                            m_act[i] = 0; m_done[i] = 1; m_busy[i] = 0;
                            m_valid[i] = 1; m_din[i] = '0;
                        end else begin
                            m_c[i]++;
                            m_din[i] = ord(m_c[i] / per);
                        end
                    end else begin
                        m_c[i]++;
                    end
                end else if (m_done[i]) begin
                    m_done[i] = 0;
                end else if (start[i]) begin
                    m_act[i] = 1; m_c[i] = 0; m_din[i] = '0; m_busy[i] = 1;
                    m_tab[i] = '0; m_valid[i] = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] seq [8];

    // Pulses start, returns cycles from the accepting edge to done, and the
    // combination seen at the start of each hold window.
    task automatic run_sweep(input int i, output int lat);
        int per;
        per = st[i] + 1;
        lat = -1;
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
        seq[0] = din_w[i];
        for (int k = 1; k < 300; k++) begin
            tick();
            if (k % per == 0 && k / per < 8) seq[k / per] = din_w[i];
            if (done_w[i]) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            errors++;
            $display("FAIL sweep_timeout[%0d] no done within 300 cycles", i);
        end
    endtask

    int         lat;
    int         ndone;
    logic [2:0] exp_seq [4];

    initial begin
`ifdef SWEEP_GRAY_EN
        exp_seq = '{3'd0, 3'd1, 3'd3, 3'd2};
`else
        exp_seq = '{3'd0, 3'd1, 3'd2, 3'd3};
`endif
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_busy", 0, 32'(busy0), 32'd0);
        chk("reset_table", 0, 32'(tab0), 32'd0);
        rst = 1'b0;
        tick();

        // basic sweep, output 1 only for {in2,in1}=10
        gsel[0] = 0;
        run_sweep(0, lat);
        chk("latency", 0, 32'(lat), 32'd12);
        for (int j = 0; j < 4; j++) chk("seq", j, 32'(seq[j]), 32'(exp_seq[j]));
        chk("table_lit", 0, 32'(tab0), 32'h4);
        chk("valid_lit", 0, 32'(valid0), 32'd1);
        repeat (3) tick();

        // reset on the 5th cycle of a sweep
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", 0, 32'(busy0), 32'd0);
        chk("rst_din", 0, 32'(dut_in0), 32'd0);
        chk("rst_table", 0, 32'(tab0), 32'd0);
        chk("rst_valid", 0, 32'(valid0), 32'd0);
        tick();
        run_sweep(0, lat);
        chk("latency_after_rst", 0, 32'(lat), 32'd12);
        chk("table_after_rst", 0, 32'(tab0), 32'h4);
        tick();

        // start re-pulsed while busy: ignored
        ndone = 0;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int k = 1; k < 30; k++) begin
            if (k == 4) start[0] = 1'b1;
            if (k == 5) start[0] = 1'b0;
            tick();
            if (done0) begin
                ndone++;
                if (ndone == 1) chk("latency_busy_start", 0, 32'(k), 32'd12);
            end
        end
        chk("done_count", 0, 32'(ndone), 32'd1);

        // XOR gate with output inverted outside the sample cycle
        gsel[0] = 1;
        noise_en[0] = 1'b1;
        tick();
        run_sweep(0, lat);
        chk("table_xor_lit", 0, 32'(tab0), 32'h6);
        noise_en[0] = 1'b0;
        tick();

        // start held high across done: a second sweep follows, clearing the table
        gsel[0] = 0;
        start[0] = 1'b1;
        repeat (16) tick();
        start[0] = 1'b0;
        chk("restart_valid", 0, 32'(valid0), 32'd0);
        repeat (14) tick();

        // 3-input AND, SETTLE=1
        gsel[1] = 2;
        run_sweep(1, lat);
        chk("latency3", 1, 32'(lat), 32'd16);
        chk("table_and3_lit", 1, 32'(tab1), 32'h80);
        for (int j = 0; j < 4; j++) chk("seq3", j, 32'(seq[j]), 32'(exp_seq[j]));
        tick();

        // 3-input OR with settle-phase noise
        gsel[1] = 3;
        noise_en[1] = 1'b1;
        run_sweep(1, lat);
        chk("table_or3_lit", 1, 32'(tab1), 32'hFE);
        noise_en[1] = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage that sits directly upstream of a combinational truth-table gate.
- It drives the gate's inputs through every input combination and waits a programmable settle time after each one.
- It samples the gate's single output for each combination and assembles the result into a 2^NUM_IN-bit truth-table vector.
- The netlist flow uses this vector to check synthesized gates against their intended logic function.

Parameters:
- NUM_IN, 2, number of gate inputs; legal 1..8.
- SETTLE, 2, cycles to wait after applying a combination before sampling; legal 1..255.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  sweep request; sampled only in IDLE.
- dut_in  output  NUM_IN  drives the gate inputs; bit0 = in1, bit1 = in2, ...
- dut_out  input  1  gate output being characterized.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- table_out  output  2^NUM_IN  captured table; bit k = gate output for input value k.
- table_valid  output  1  high from done until the next accepted start or rst.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; dut_in=0, busy=0, done=0, table_out=0, table_valid=0, idx=0, cnt=0. Reset mid-sweep aborts immediately; no partial table is retained.
- All outputs are registered.
- States:
  - IDLE: busy=0, dut_in=0. start=1 at an edge moves to SETTLE with idx=0, cnt=0, dut_in=0, busy=1, table_out=0, table_valid=0.
  - SETTLE: cnt increments each cycle. At the edge where cnt==SETTLE-1, move to SAMPLE.
  - SAMPLE (one cycle): table_out[idx] <= dut_out.
    - If idx==2^NUM_IN-1: move to DONE, dut_in=0.
    - Else: idx=idx+1, dut_in=next combination, cnt=0, move to SETTLE.
  - DONE (one cycle): done=1, busy=0, table_valid=1, then move to IDLE. done is 0 in every other state.
- Timing:
  - Each combination is held for exactly SETTLE+1 cycles.
  - done is high in the cycle that begins 2^NUM_IN*(SETTLE+1) cycles after the start-accepting edge.
- start while busy or in DONE is ignored and not queued. start held high in IDLE after DONE begins a new sweep, which clears table_out and table_valid.
- The index counter is NUM_IN+1 bits wide so the last-index compare never wraps. The settle counter is 8 bits.
- dut_out is sampled only in SAMPLE; changes during SETTLE are ignored.
- NUM_IN=1 produces a 2-bit table; no special casing is needed.

Optional Feature:
- Macro: SWEEP_GRAY_EN.
- When defined: combinations are applied in reflected Gray-code order (dut_in = idx ^ (idx>>1)), so only one input toggles per step.
  - table_out is still indexed by the binary value of dut_in: bit (idx^(idx>>1)) <= dut_out.
  - The final dut_in before returning to 0 is the Gray code of 2^NUM_IN-1.
- When undefined: dut_in = idx, binary order.
- table_out contents and timing are identical in both modes for a purely combinational gate.

Test Plan:
- NUM_IN=2, SETTLE=2, DUT output 1 only for {in2,in1}=2'b10. Pulse start → dut_in sequence 0,1,2,3, each held 3 cycles; done pulses 12 cycles after the accepting edge; table_out=4'b0100, table_valid=1.
- Same DUT with SWEEP_GRAY_EN defined → dut_in sequence 0,1,3,2; table_out=4'b0100; same done timing.
- Assert rst for one cycle on the 5th cycle of a sweep → next cycle busy=0, dut_in=0, table_out=0, table_valid=0. A new start then yields the full correct table.
- Pulse start again while busy=1 → sweep timing is unchanged and only one done pulse occurs.
- NUM_IN=3, SETTLE=1, DUT = 3-input AND → table_out=8'b1000_0000; done 16 cycles after start.
- DUT output toggles during SETTLE but is stable at SAMPLE → only the SAMPLE-cycle value is captured in table_out.
